pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Multicycle instruction sequencer that owns the architectural PC register and drives the select of the next-PC datapath. Each instruction runs through fetch, decode, execute, optional memory and writeback phases. The block handshakes with instruction and data memory, writes the instruction register and register file, and commits `next_pc` once per retired instruction. It sits between the memory interface and the next-PC/ALU datapath and is the only writer of `pc`.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `run` in 1: allows fetching of new instructions.
- `opcode` in 7: instr[6:0] from the instruction register; valid from DECODE onward.
- `mem_ready` in 1: memory acknowledge, shared by imem and dmem.
- `next_pc` in 32: next-PC datapath result, computed from `pc` and `pc_source`.
- `pc` out 32: current PC; feeds the datapath `pc_in` and the imem address.
- `pc_source` out 2: 00 JALR, 01 JAL, 10 branch (ALU result selects), 11 PC+4.
- `imem_req` out 1: instruction fetch request.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: data write enable.
- `ir_we` out 1: instruction register load.
- `reg_we` out 1: register file write.
- `busy` out 1: high in any state except IDLE.
- `instret` out 32: retired-instruction counter.
- `trap` out 1: misaligned-PC trap; present only with the macro.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, plus HALT with the macro.
- IDLE:
  - When `run`=1, go to FETCH; otherwise stay.
- FETCH:
  - `imem_req`=1 while in this state.
  - On the cycle with `mem_ready`=1, `ir_we`=1 and the next state is DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle, then EXECUTE.
- EXECUTE: one cycle.
  - LOAD (0000011) or STORE (0100011): go to MEM.
  - Any other opcode: go to WB.
- MEM:
  - `dmem_req`=1 while in this state.
  - `dmem_we`=1 for STORE only.
  - Leave for WB on `mem_ready`=1.
- WB: one cycle.
  - `reg_we`=1 for LOAD, OP, OP-IMM, LUI, AUIPC, JAL, JALR.
  - `reg_we`=0 for STORE, BRANCH and unknown opcodes; unknown opcodes execute as no-ops.
  - `pc` <= `next_pc` and `instret` += 1.
  - Go to FETCH if `run`=1, else IDLE.
- `pc_source` is combinational from `opcode`:
  - JAL (1101111) gives 01, JALR (1100111) gives 00, BRANCH (1100011) gives 10.
  - All other opcodes give 11.
  - It is only meaningful in WB.
- Deasserting `run` mid-instruction does not abort: the instruction completes and retires. `run` is sampled only in IDLE and WB.
- `instret` wraps from FFFF_FFFF to 0.
- Only one of `imem_req`/`dmem_req` is ever high.

## Timing
- Reset values:
  - `pc`=RESET_PC, `instret`=0, state IDLE.
  - All strobes (`imem_req`, `dmem_req`, `dmem_we`, `ir_we`, `reg_we`) =0.
  - `busy`=0, `trap`=0.
- Reset asserted mid-operation takes effect immediately and asynchronously. Any memory request drops the same cycle.
- Outputs are registered-state Moore decodes, except:
  - `ir_we`, which is gated by `mem_ready`;
  - `pc_source`, which is decoded from `opcode`.
- Zero-wait memory:
  - non-memory instruction: 4 cycles (FETCH, DECODE, EXECUTE, WB);
  - load/store: 5 cycles.
- Each wait cycle, where `mem_ready`=0 while requesting, adds 1 cycle.
- The new `pc` is visible the cycle after WB, which is the first FETCH cycle.
- `mem_ready` outside FETCH/MEM is ignored.

## Configuration
- Macro: `PC_MISALIGN_TRAP_EN`.
- Defined: in WB, if `next_pc[1:0]`≠00:
  - `pc` holds, `reg_we`=0, and `instret` does not increment;
  - the FSM enters HALT, with `trap`=1 and `busy`=1;
  - only reset exits HALT.
- Undefined:
  - `pc` <= {`next_pc[31:2]`, 2'b00};
  - no `trap` port and no HALT state.

## Structure
- Package `pc_seq_pkg` holds:
  - the state enum;
  - opcode constants (LOAD, STORE, BRANCH, JAL, JALR, OP, OP_IMM, LUI, AUIPC);
  - `pc_source` encodings.
- Sub-module `opcode_class` is combinational. It maps `opcode` to `is_mem`, `is_store`, `writes_rd` and `pc_source`.
- The top level holds the FSM, the PC register and the `instret` counter.

## Test plan
- Reset, RESET_PC=32'h100, `run`=1, ADDI (0010011), `mem_ready` always 1, `next_pc`=32'h104:
  - FETCH, DECODE, EXECUTE, WB in 4 cycles;
  - `reg_we` pulses in WB;
  - `pc`=32'h104 and `instret`=1 afterwards.
- LOAD with 2 wait cycles in FETCH and 3 in MEM:
  - 10 cycles total;
  - `dmem_we`=0 throughout;
  - `reg_we` in WB only.
- STORE, BRANCH, JAL, JALR:
  - `pc_source` = 11, 10, 01, 00 respectively in WB;
  - `dmem_we`=1 only for STORE in MEM;
  - `reg_we`=0 for STORE and BRANCH.
- Drop `run` during EXECUTE: the instruction retires and the FSM goes to IDLE with `busy`=0. Raise `run` again: FETCH resumes at the updated `pc`.
- Assert `rst_n`=0 during MEM while `dmem_req`=1:
  - same cycle: `dmem_req`=0 and state IDLE;
  - `pc`=RESET_PC and `instret`=0.
- `next_pc`=32'h202 in WB:
  - with `PC_MISALIGN_TRAP_EN`: `trap`=1, `pc` unchanged, `instret` unchanged, stays halted;
  - without it: `pc`=32'h200.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the pc_sequencer block: FSM state encoding,
// RV32 major-opcode constants and the next-PC select encodings.
// The HALT state exists only when PC_MISALIGN_TRAP_EN is defined.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5
`ifdef PC_MISALIGN_TRAP_EN
        , ST_HALT  = 3'd6
`endif
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [1:0] PCS_JALR   = 2'b00;
    localparam logic [1:0] PCS_JAL    = 2'b01;
    localparam logic [1:0] PCS_BRANCH = 2'b10;
    localparam logic [1:0] PCS_PLUS4  = 2'b11;

endpackage

// File: rtl/pc_sequencer_opcode_class.sv
// opcode_class: purely combinational classification of the major opcode into
// the few attributes the sequencer needs. Unknown opcodes behave as no-ops.
module opcode_class
    import pc_seq_pkg::*;
(
    input  logic [6:0] i_opcode,
    output logic       o_is_mem,
    output logic       o_is_store,
    output logic       o_writes_rd,
    output logic [1:0] o_pc_source
);

    // Decode opcode into access type, rd write and next-PC select.
    always_comb begin
        o_is_mem    = 1'b0;
        o_is_store  = 1'b0;
        o_writes_rd = 1'b0;
        o_pc_source = PCS_PLUS4;
        case (i_opcode)
            OPC_LOAD: begin
                o_is_mem    = 1'b1;
                o_writes_rd = 1'b1;
            end
            OPC_STORE: begin
                o_is_mem   = 1'b1;
                o_is_store = 1'b1;
            end
            OPC_BRANCH: o_pc_source = PCS_BRANCH;
            OPC_JAL: begin
                o_writes_rd = 1'b1;
                o_pc_source = PCS_JAL;
            end
            OPC_JALR: begin
                o_writes_rd = 1'b1;
                o_pc_source = PCS_JALR;
            end
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: o_writes_rd = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle FETCH/DECODE/EXECUTE/[MEM]/WB sequencer that owns
// the architectural PC and the retired-instruction counter.
// Optional feature macro: PC_MISALIGN_TRAP_EN -- a misaligned next_pc in WB
// halts the sequencer with trap=1 instead of force-aligning the PC.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    input  logic [31:0] next_pc,
    output logic [31:0] pc,
    output logic [1:0]  pc_source,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic        busy,
    output logic [31:0] instret
`ifdef PC_MISALIGN_TRAP_EN
    , output logic      trap
`endif
);

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_instret;
    logic        w_is_mem;
    logic        w_is_store;
    logic        w_writes_rd;
    logic        w_misalign;
    logic        w_retire;

    opcode_class u_opcode_class (
        .i_opcode    (opcode),
        .o_is_mem    (w_is_mem),
        .o_is_store  (w_is_store),
        .o_writes_rd (w_writes_rd),
        .o_pc_source (pc_source)
    );

`ifdef PC_MISALIGN_TRAP_EN
    assign w_misalign = (next_pc[1:0] != 2'b00);
    assign trap       = (r_state == ST_HALT);
`else
    assign w_misalign = 1'b0;
`endif

    // A misaligned target never retires, so the masked write below only
    // changes the value in the force-align build.
    assign w_retire = (r_state == ST_WB) && !w_misalign;
    assign busy     = (r_state != ST_IDLE);
    assign pc       = r_pc;
    assign instret  = r_instret;

    // State register; reset drops every request in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state and Moore strobes; ir_we is the one strobe gated by mem_ready.
    always_comb begin
        w_next_state = r_state;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ir_we        = 1'b0;
        reg_we       = 1'b0;
        case (r_state)
            ST_IDLE: if (run) w_next_state = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_we    = mem_ready;
                if (mem_ready) w_next_state = ST_DECODE;
            end
            ST_DECODE:  w_next_state = ST_EXECUTE;
            ST_EXECUTE: w_next_state = w_is_mem ? ST_MEM : ST_WB;
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = w_is_store;
                if (mem_ready) w_next_state = ST_WB;
            end
            ST_WB: begin
                reg_we = w_writes_rd && !w_misalign;
`ifdef PC_MISALIGN_TRAP_EN
                if (w_misalign)  w_next_state = ST_HALT;
                else if (run)    w_next_state = ST_FETCH;
                else             w_next_state = ST_IDLE;
`else
                w_next_state = run ? ST_FETCH : ST_IDLE;
`endif
            end
`ifdef PC_MISALIGN_TRAP_EN
            ST_HALT: w_next_state = ST_HALT;
`endif
            default: w_next_state = ST_IDLE;
        endcase
    end

    // PC and retired-instruction counter advance together at retirement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_instret <= 32'd0;
        end else if (w_retire) begin
            r_pc      <= next_pc & ~32'h3;
            r_instret <= r_instret + 32'd1;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer. The reference model expands each
// instruction into its list of phases and derives per-cycle strobes, the
// next-PC select and the architectural PC/instret from the instruction rules.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    localparam int P_FETCH = 1;
    localparam int P_DEC   = 2;
    localparam int P_EXEC  = 3;
    localparam int P_MEM   = 4;
    localparam int P_WB    = 5;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic [31:0] next_pc;
    logic [31:0] pc;
    logic [1:0]  pc_source;
    logic        imem_req, dmem_req, dmem_we, ir_we, reg_we, busy;
    logic [31:0] instret;
`ifdef PC_MISALIGN_TRAP_EN
    logic        trap;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc;
    logic [31:0] m_instret;

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .next_pc   (next_pc),
        .pc        (pc),
        .pc_source (pc_source),
        .imem_req  (imem_req),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .ir_we     (ir_we),
        .reg_we    (reg_we),
        .busy      (busy),
        .instret   (instret)
`ifdef PC_MISALIGN_TRAP_EN
        , .trap    (trap)
`endif
    );

    always #5 clk = ~clk;

    // Runs one instruction starting in its first FETCH cycle and checks every
    // cycle up to and including WB against the phase model.
    task automatic do_instr(input logic [6:0] op, input int fw, input int mw,
                            input logic [31:0] npc, input bit drop_run, input string nm);
        int         q[$];
        bit         is_mem, is_st, wr, trap_case;
        logic [1:0] src;
        int         fcnt, mcnt;
        logic [5:0] got, exp;
        is_mem = (op == LOAD) || (op == STORE);
        is_st  = (op == STORE);
        case (op)
            LOAD, OP, OPIMM, LUI, AUIPC, JAL, JALR: wr = 1'b1;
            default:                                wr = 1'b0;
        endcase
        case (op)
            JAL:     src = 2'b01;
            JALR:    src = 2'b00;
            BRANCH:  src = 2'b10;
            default: src = 2'b11;
        endcase
`ifdef PC_MISALIGN_TRAP_EN
        trap_case = (npc[1:0] != 2'b00);
`else
        trap_case = 1'b0;
`endif
        for (int i = 0; i <= fw; i++) q.push_back(P_FETCH);
        q.push_back(P_DEC);
        q.push_back(P_EXEC);
        if (is_mem) for (int i = 0; i <= mw; i++) q.push_back(P_MEM);
        q.push_back(P_WB);
        fcnt = 0;
        mcnt = 0;
        opcode = op;
        foreach (q[k]) begin
            @(negedge clk);
            case (q[k])
                P_FETCH: begin mem_ready = (fcnt == fw); fcnt++; end
                P_MEM:   begin mem_ready = (mcnt == mw); mcnt++; end
                default: mem_ready = 1'($urandom_range(0, 1));
            endcase
            if (drop_run && q[k] == P_EXEC) run = 1'b0;
            next_pc = (q[k] == P_WB) ? npc : $urandom;
            #1;
            if (k == 0) begin
                checks++;
                if (pc !== m_pc || instret !== m_instret) begin
                    errors++;
                    $display("FAIL %s arch_state: pc=%h instret=%0d expected pc=%h instret=%0d",
                             nm, pc, instret, m_pc, m_instret);
                end
            end
            got = {imem_req, dmem_req, dmem_we, ir_we, reg_we, busy};
            exp = {q[k] == P_FETCH, q[k] == P_MEM, q[k] == P_MEM && is_st,
                   q[k] == P_FETCH && mem_ready, q[k] == P_WB && wr && !trap_case, 1'b1};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s strobes cycle %0d phase %0d: {imem,dmem,we,ir,reg,busy}=%b expected %b",
                         nm, k, q[k], got, exp);
            end
            if (q[k] == P_WB) begin
                checks++;
                if (pc_source !== src) begin
                    errors++;
                    $display("FAIL %s pc_source: got %b expected %b", nm, pc_source, src);
                end
            end
        end
        if (!trap_case) begin
            m_pc      = {npc[31:2], 2'b00};
            m_instret = m_instret + 32'd1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; mem_ready = 1'b1; opcode = 7'd0; next_pc = 32'd0;
        m_pc = RST_PC; m_instret = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({imem_req, dmem_req, dmem_we, ir_we, reg_we, busy} !== 6'b0 ||
            pc !== RST_PC || instret !== 32'd0) begin
            errors++;
            $display("FAIL reset: strobes=%b pc=%h instret=%0d expected 000000 %h 0",
                     {imem_req, dmem_req, dmem_we, ir_we, reg_we, busy}, pc, instret, RST_PC);
        end
`ifdef PC_MISALIGN_TRAP_EN
        checks++;
        if (trap !== 1'b0) begin errors++; $display("FAIL reset_trap: got %b expected 0", trap); end
`endif
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_run: busy=%b imem_req=%b expected 0 0", busy, imem_req);
        end
        run = 1'b1;
    endtask

    task automatic test_addi();
        do_instr(OPIMM, 0, 0, 32'h104, 1'b0, "addi");
    endtask

    task automatic test_load_waits();
        do_instr(LOAD, 2, 3, 32'h108, 1'b0, "load_waits");
    endtask

    task automatic test_pc_source();
        do_instr(STORE,  0, 1, 32'h10C, 1'b0, "store");
        do_instr(BRANCH, 1, 0, 32'h200, 1'b0, "branch");
        do_instr(JAL,    0, 0, 32'h300, 1'b0, "jal");
        do_instr(JALR,   0, 0, 32'h180, 1'b0, "jalr");
    endtask

    task automatic test_run_drop();
        do_instr(OP, 0, 0, 32'h1F0, 1'b1, "run_drop");
        repeat (2) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (busy !== 1'b0 || imem_req !== 1'b0 || pc !== m_pc || instret !== m_instret) begin
                errors++;
                $display("FAIL run_drop_idle: busy=%b imem=%b pc=%h instret=%0d expected 0 0 %h %0d",
                         busy, imem_req, pc, instret, m_pc, m_instret);
            end
        end
        run = 1'b1;
        do_instr(AUIPC, 0, 0, 32'h1F4, 1'b0, "run_resume");
    endtask

    task automatic test_random();
        logic [6:0]  ops [12];
        logic [31:0] npc;
        ops = '{LOAD, STORE, BRANCH, JAL, JALR, OP, OPIMM, LUI, AUIPC,
                7'b1110011, 7'b0001111, 7'b1111111};
        for (int n = 0; n < 24; n++) begin
            npc = $urandom;
`ifdef PC_MISALIGN_TRAP_EN
            npc[1:0] = 2'b00;
`endif
            do_instr(ops[$urandom_range(0, 11)], $urandom_range(0, 3), $urandom_range(0, 3),
                     npc, 1'b0, "random");
        end
    endtask

    task automatic test_reset_mid_mem();
        opcode = LOAD;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            mem_ready = (c == 0);
            #1;
        end
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_mem_setup: dmem_req=%b expected 1", dmem_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || busy !== 1'b0 || pc !== RST_PC || instret !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: dmem_req=%b busy=%b pc=%h instret=%0d expected 0 0 %h 0",
                     dmem_req, busy, pc, instret, RST_PC);
        end
        m_pc = RST_PC;
        m_instret = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        run = 1'b1;
    endtask

    task automatic test_misalign();
        do_instr(OPIMM, 0, 0, 32'h202, 1'b0, "misalign");
`ifdef PC_MISALIGN_TRAP_EN
        repeat (3) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            run = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (trap !== 1'b1 || busy !== 1'b1 || imem_req !== 1'b0 ||
                pc !== m_pc || instret !== m_instret) begin
                errors++;
                $display("FAIL halt: trap=%b busy=%b imem=%b pc=%h instret=%0d expected 1 1 0 %h %0d",
                         trap, busy, imem_req, pc, instret, m_pc, m_instret);
            end
        end
`else
        @(negedge clk); #1;
        checks++;
        if (pc !== 32'h200 || instret !== m_instret) begin
            errors++;
            $display("FAIL force_align: pc=%h instret=%0d expected 00000200 %0d", pc, instret, m_instret);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_waits();
        test_pc_source();
        test_run_drop();
        test_random();
        test_reset_mid_mem();
        test_addi();
        test_misalign();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within bound");
        $fatal(1, "timeout");
    end

endmodule
